// File: rtl/enemy_wave_scheduler.sv
// enemy_wave_scheduler: spawns enemy slots one per gap, tracks which enemies are alive,
// and steps through waves and levels. It also drives the shared speed and the global pause.
module enemy_wave_scheduler #(
  parameter int NUM_ENEMIES        = 4,
  parameter int BASE_SPEED         = 64,
  parameter int SPEED_STEP         = 16,
  parameter int MAX_SPEED          = 256,
  parameter int SPAWN_GAP_FRAMES   = 30,
  parameter int CLEAR_DELAY_FRAMES = 120,
  parameter int MAX_LEVEL          = 9
) (
  input  logic                   clk,
  input  logic                   resetN,
  input  logic                   startOfFrame,
  input  logic                   startGame,
  input  logic                   pauseReq,
  input  logic                   gameOver,
  input  logic [NUM_ENEMIES-1:0] enemyHit,
  output logic [NUM_ENEMIES-1:0] restartLoc,
  output logic [NUM_ENEMIES-1:0] enemyAlive,
  output logic [10:0]            enemySpeed,
  output logic                   pause,
  output logic [3:0]             level,
  output logic                   waveCleared,
  output logic [2:0]             gameState
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SPAWN  = 3'd1,
    ST_ACTIVE = 3'd2,
    ST_CLEAR  = 3'd3,
    ST_OVER   = 3'd4
  } state_t;

  localparam int CNT_W = 16;

  state_t                 state, state_nxt;
  logic [2:0]             slot, slot_nxt;
  logic [CNT_W-1:0]       frame_cnt, frame_cnt_nxt;
  logic                   pause_req_d;
  logic [NUM_ENEMIES-1:0] restart_nxt, alive_nxt;
  logic                   pause_nxt, cleared_nxt;
  logic [3:0]             level_nxt;
  logic [10:0]            speed_nxt;
  logic                   in_play, frame_run, pause_edge;

  // Level increment that sticks at MAX_LEVEL.
  function automatic logic [3:0] next_level(input logic [3:0] cur);
    if (cur >= 4'(MAX_LEVEL)) return 4'(MAX_LEVEL);
    return cur + 4'd1;
  endfunction

  // Speed for a level, saturated at MAX_SPEED in 16 bits and then narrowed to the port width.
  function automatic logic [10:0] level_speed(input logic [3:0] lvl);
    logic [15:0] raw;
    raw = 16'(BASE_SPEED) + 16'(lvl) * 16'(SPEED_STEP);
    if (raw > 16'(MAX_SPEED)) raw = 16'(MAX_SPEED);
    return raw[10:0];
  endfunction

  assign gameState = state;

  // Next-state and next-output decisions for the game flow.
  always_comb begin
    state_nxt     = state;
    slot_nxt      = slot;
    frame_cnt_nxt = frame_cnt;
    pause_nxt     = pause;
    level_nxt     = level;
    speed_nxt     = enemySpeed;
    restart_nxt   = '0;
    cleared_nxt   = 1'b0;
    alive_nxt     = enemyAlive & ~enemyHit;
    in_play       = (state == ST_SPAWN) || (state == ST_ACTIVE) || (state == ST_CLEAR);
    frame_run     = startOfFrame & ~pause;
    pause_edge    = pauseReq & ~pause_req_d;

    if (in_play && gameOver) begin
      // Losing the game overrides any spawn or level change this clock.
      state_nxt = ST_OVER;
      alive_nxt = '0;
      pause_nxt = 1'b1;
    end else begin
      if (in_play && pause_edge) pause_nxt = ~pause;
      case (state)
        ST_IDLE, ST_OVER: begin
          if (state == ST_OVER) alive_nxt = '0;
          if (startGame) begin
            state_nxt     = ST_SPAWN;
            level_nxt     = 4'd0;
            speed_nxt     = 11'(BASE_SPEED);
            pause_nxt     = 1'b0;
            slot_nxt      = 3'd0;
            frame_cnt_nxt = '0;
          end
        end
        ST_SPAWN: begin
          if (frame_run) begin
            if (frame_cnt == '0) begin
              // Spawn beats a same-clock hit on the same slot, so it is applied last.
              for (int k = 0; k < NUM_ENEMIES; k++) begin
                if (slot == 3'(k)) begin
                  restart_nxt[k] = 1'b1;
                  alive_nxt[k]   = 1'b1;
                end
              end
              frame_cnt_nxt = CNT_W'(SPAWN_GAP_FRAMES - 1);
              slot_nxt      = slot + 3'd1;
              if (slot == 3'(NUM_ENEMIES - 1)) state_nxt = ST_ACTIVE;
            end else begin
              frame_cnt_nxt = frame_cnt - 1'b1;
            end
          end
        end
        ST_ACTIVE: begin
          if (enemyAlive == '0) begin
            cleared_nxt   = 1'b1;
            frame_cnt_nxt = CNT_W'(CLEAR_DELAY_FRAMES - 1);
            state_nxt     = ST_CLEAR;
          end
        end
        ST_CLEAR: begin
          if (frame_run) begin
            if (frame_cnt == '0) begin
              level_nxt     = next_level(level);
              speed_nxt     = level_speed(next_level(level));
              slot_nxt      = 3'd0;
              frame_cnt_nxt = '0;
              state_nxt     = ST_SPAWN;
            end else begin
              frame_cnt_nxt = frame_cnt - 1'b1;
            end
          end
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  // State and output registers; reset cuts any pulse in flight.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state       <= ST_IDLE;
      slot        <= 3'd0;
      frame_cnt   <= '0;
      pause_req_d <= 1'b0;
      restartLoc  <= '0;
      enemyAlive  <= '0;
      enemySpeed  <= 11'(BASE_SPEED);
      pause       <= 1'b0;
      level       <= 4'd0;
      waveCleared <= 1'b0;
    end else begin
      state       <= state_nxt;
      slot        <= slot_nxt;
      frame_cnt   <= frame_cnt_nxt;
      pause_req_d <= pauseReq;
      restartLoc  <= restart_nxt;
      enemyAlive  <= alive_nxt;
      enemySpeed  <= speed_nxt;
      pause       <= pause_nxt;
      level       <= level_nxt;
      waveCleared <= cleared_nxt;
    end
  end

endmodule

// File: tb/tb_enemy_wave_scheduler.sv
// Testbench for enemy_wave_scheduler: a frame-counting reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_enemy_wave_scheduler;

  localparam int N     = 4;
  localparam int BASE  = 64;
  localparam int STEP  = 16;
  localparam int MAXSP = 128;
  localparam int GAP   = 30;
  localparam int CLRD  = 120;
  localparam int MAXL  = 9;

  logic         clk = 1'b0;
  logic         resetN = 1'b0;
  logic         startOfFrame = 1'b0;
  logic         startGame = 1'b0;
  logic         pauseReq = 1'b0;
  logic         gameOver = 1'b0;
  logic [N-1:0] enemyHit = '0;
  logic [N-1:0] restartLoc, enemyAlive;
  logic [10:0]  enemySpeed;
  logic         pause, waveCleared;
  logic [3:0]   level;
  logic [2:0]   gameState;

  int checks = 0;
  int failures = 0;
  bit cmp_en = 0;
  int sof_num = 0;
  int log_n = 0;
  int log_frame [16];
  int log_val [16];
  int wc_n = 0;

  enemy_wave_scheduler #(
    .NUM_ENEMIES(N), .BASE_SPEED(BASE), .SPEED_STEP(STEP), .MAX_SPEED(MAXSP),
    .SPAWN_GAP_FRAMES(GAP), .CLEAR_DELAY_FRAMES(CLRD), .MAX_LEVEL(MAXL)
  ) dut (
    .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame), .startGame(startGame),
    .pauseReq(pauseReq), .gameOver(gameOver), .enemyHit(enemyHit),
    .restartLoc(restartLoc), .enemyAlive(enemyAlive), .enemySpeed(enemySpeed),
    .pause(pause), .level(level), .waveCleared(waveCleared), .gameState(gameState)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      if (failures <= 40)
        $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: phases 0..4, counts unpaused frames upward within a phase.
  int         m_phase = 0;
  int         m_sofs = 0;
  logic [3:0] m_alive = '0;
  logic [3:0] m_restart = '0;
  bit         m_pause = 0;
  bit         m_prev = 0;
  bit         m_wc = 0;
  int         m_level = 0;

  function automatic int speed_of(input int lvl);
    int s;
    s = BASE + lvl * STEP;
    return (s > MAXSP) ? MAXSP : s;
  endfunction

  task automatic model_over();
    m_phase = 4; m_alive = '0; m_pause = 1; m_restart = '0; m_wc = 0;
  endtask

  always @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      m_phase = 0; m_sofs = 0; m_alive = '0; m_restart = '0;
      m_pause = 0; m_prev = 0; m_wc = 0; m_level = 0;
    end else begin
      logic [3:0] old_alive;
      bit         edge_seen, run;
      edge_seen = pauseReq && !m_prev;
      m_prev    = pauseReq;
      run       = startOfFrame && !m_pause;
      old_alive = m_alive;
      m_alive   = m_alive & ~enemyHit;
      m_restart = '0;
      m_wc      = 0;
      if (m_phase >= 1 && m_phase <= 3 && gameOver) begin
        model_over();
      end else begin
        if (m_phase >= 1 && m_phase <= 3 && edge_seen) m_pause = !m_pause;
        case (m_phase)
          0, 4: begin
            if (m_phase == 4) m_alive = '0;
            if (startGame) begin
              m_phase = 1; m_level = 0; m_pause = 0; m_sofs = 0;
            end
          end
          1: if (run) begin
            if (m_sofs % GAP == 0) begin
              m_restart = 4'(1 << (m_sofs / GAP));
              m_alive   = m_alive | m_restart;
              if (m_sofs / GAP == N - 1) m_phase = 2;
            end
            m_sofs++;
          end
          2: if (old_alive == 0) begin
            m_wc = 1; m_phase = 3; m_sofs = 0;
          end
          3: if (run) begin
            m_sofs++;
            if (m_sofs == CLRD) begin
              m_level = (m_level + 1 > MAXL) ? MAXL : m_level + 1;
              m_phase = 1; m_sofs = 0;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (cmp_en) begin
      check("m_gameState", 32'(gameState), 32'(m_phase));
      check("m_restartLoc", 32'(restartLoc), 32'(m_restart));
      check("m_enemyAlive", 32'(enemyAlive), 32'(m_alive));
      check("m_enemySpeed", 32'(enemySpeed), 32'(speed_of(m_level)));
      check("m_pause", 32'(pause), 32'(m_pause));
      check("m_level", 32'(level), 32'(m_level));
      check("m_waveCleared", 32'(waveCleared), 32'(m_wc));
    end
  end

  // Record each respawn pulse with the frame number that triggered it.
  always @(negedge clk) begin
    if (resetN && restartLoc != 0 && log_n < 16) begin
      log_frame[log_n] = sof_num;
      log_val[log_n]   = int'(restartLoc);
      log_n++;
    end
    if (waveCleared === 1'b1) wc_n++;
  end

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk); startOfFrame = 1'b1; sof_num++;
      @(negedge clk); startOfFrame = 1'b0;
      @(negedge clk);
      @(negedge clk);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_state"}, 32'(gameState), 32'd0);
    check({tag, "_restart"}, 32'(restartLoc), 32'd0);
    check({tag, "_alive"}, 32'(enemyAlive), 32'd0);
    check({tag, "_speed"}, 32'(enemySpeed), 32'd64);
    check({tag, "_pause"}, 32'(pause), 32'd0);
    check({tag, "_level"}, 32'(level), 32'd0);
    check({tag, "_wc"}, 32'(waveCleared), 32'd0);
  endtask

  int         exp_f [4] = '{1, 31, 61, 91};
  int         exp_v [4] = '{1, 2, 4, 8};
  logic [3:0] hits [4]  = '{4'b0100, 4'b0001, 4'b1000, 4'b0010};
  logic [3:0] alv  [4]  = '{4'b1011, 4'b1010, 4'b0010, 4'b0000};

  initial begin
    // Reset state.
    repeat (3) @(negedge clk);
    check_reset_values("rst");
    resetN = 1'b1;
    cmp_en = 1;

    // Start and first wave spawn sequence.
    @(negedge clk); startGame = 1'b1;
    @(negedge clk); startGame = 1'b0;
    check("start_state", 32'(gameState), 32'd1);
    sof_num = 0; log_n = 0;
    frames(91);
    check("spawn_count", 32'(log_n), 32'd4);
    for (int i = 0; i < 4; i++) begin
      check("spawn_frame", 32'(log_frame[i]), 32'(exp_f[i]));
      check("spawn_slot", 32'(log_val[i]), 32'(exp_v[i]));
    end
    check("wave1_alive", 32'(enemyAlive), 32'b1111);
    check("wave1_active", 32'(gameState), 32'd2);

    // Hits in order 2, 0, 3, 1.
    wc_n = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); enemyHit = hits[i];
      @(negedge clk); enemyHit = '0;
      check("hit_alive", 32'(enemyAlive), 32'(alv[i]));
    end
    @(negedge clk);
    check("wc_pulse", 32'(waveCleared), 32'd1);
    check("wc_state", 32'(gameState), 32'd3);
    @(negedge clk);
    check("wc_drop", 32'(waveCleared), 32'd0);
    frames(CLRD);
    check("wc_single", 32'(wc_n), 32'd1);
    check("lvl1_state", 32'(gameState), 32'd1);
    check("lvl1_level", 32'(level), 32'd1);
    check("lvl1_speed", 32'(enemySpeed), 32'd80);

    // Twenty more waves: level and speed saturation.
    for (int w = 1; w <= 20; w++) begin
      frames(91);
      @(negedge clk); enemyHit = 4'b1111;
      @(negedge clk); enemyHit = '0;
      @(negedge clk);
      frames(CLRD);
      check("sat_level", 32'(level), 32'((w + 1 > 9) ? 9 : w + 1));
      check("sat_speed", 32'(enemySpeed), 32'((64 + 16 * (w + 1) > 128) ? 128 : 64 + 16 * (w + 1)));
    end
    check("final_level", 32'(level), 32'd9);
    check("final_speed", 32'(enemySpeed), 32'd128);

    // Pause after two spawns, held for 100 frames.
    sof_num = 0; log_n = 0;
    frames(31);
    check("p_spawns", 32'(log_n), 32'd2);
    check("p_alive0", 32'(enemyAlive), 32'b0011);
    @(negedge clk); pauseReq = 1'b1;
    @(negedge clk);
    check("p_on", 32'(pause), 32'd1);
    frames(50);
    @(negedge clk); enemyHit = 4'b0001;
    @(negedge clk); enemyHit = '0;
    check("p_hit_alive", 32'(enemyAlive), 32'b0010);
    frames(50);
    check("p_held", 32'(pause), 32'd1);
    check("p_no_spawn", 32'(log_n), 32'd2);
    @(negedge clk); pauseReq = 1'b0;
    @(negedge clk); pauseReq = 1'b1;
    @(negedge clk); pauseReq = 1'b0;
    check("p_off", 32'(pause), 32'd0);
    sof_num = 0;
    frames(29);
    check("p_resume_wait", 32'(log_n), 32'd2);
    frames(1);
    check("p_resume_cnt", 32'(log_n), 32'd3);
    check("p_resume_frame", 32'(log_frame[2]), 32'd30);
    check("p_resume_slot", 32'(log_val[2]), 32'b0100);
    frames(29);

    // Last spawn collides with a hit and gameOver.
    @(negedge clk); startOfFrame = 1'b1; gameOver = 1'b1; enemyHit = 4'b1000; sof_num++;
    @(negedge clk); startOfFrame = 1'b0; gameOver = 1'b0; enemyHit = '0;
    check("go_state", 32'(gameState), 32'd4);
    check("go_restart", 32'(restartLoc), 32'd0);
    check("go_alive", 32'(enemyAlive), 32'd0);
    check("go_pause", 32'(pause), 32'd1);
    @(negedge clk);
    check("go_no_pulse", 32'(log_n), 32'd3);
    @(negedge clk); startGame = 1'b1;
    @(negedge clk); startGame = 1'b0;
    check("rs_state", 32'(gameState), 32'd1);
    check("rs_level", 32'(level), 32'd0);
    check("rs_speed", 32'(enemySpeed), 32'd64);
    check("rs_pause", 32'(pause), 32'd0);

    // Asynchronous reset while a respawn pulse is high.
    @(negedge clk); startOfFrame = 1'b1;
    @(negedge clk); startOfFrame = 1'b0;
    check("ar_pulse", 32'(restartLoc), 32'b0001);
    #2 resetN = 1'b0;
    #1 check_reset_values("ar");
    @(negedge clk); resetN = 1'b1;
    repeat (3) @(negedge clk);
    check("ar_idle", 32'(gameState), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
